// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
// Round-robin arbiter sharing one Wishbone manager port among NUM_MANAGERS
// requesters. The grant is held for the whole cycle (cyc high), shared
// outputs follow the granted manager combinationally and the decoder's
// ack/data are routed back to the granted manager only.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a stall counter that
// force-terminates a cycle after TIMEOUT_CYCLES unacked strobe cycles. The
// terminated manager gets ack with 32'hDEAD_BEEF, and arb_timeout_o pulses.
module wishbone_arbiter #(
    parameter int NUM_MANAGERS   = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_MANAGERS-1:0]       wbm_cyc_i,
    input  logic [NUM_MANAGERS-1:0]       wbm_stb_i,
    input  logic [NUM_MANAGERS-1:0]       wbm_we_i,
    input  logic [NUM_MANAGERS-1:0][3:0]  wbm_sel_i,
    input  logic [NUM_MANAGERS-1:0][31:0] wbm_adr_i,
    input  logic [NUM_MANAGERS-1:0][31:0] wbm_dat_i,
    output logic [NUM_MANAGERS-1:0]       wbm_ack_o,
    output logic [NUM_MANAGERS-1:0][31:0] wbm_dat_o,
    output logic                          wbs_cyc_o_p,
    output logic                          wbs_stb_o_p,
    output logic                          wbs_we_o_p,
    output logic [3:0]                    wbs_sel_o_p,
    output logic [31:0]                   wbs_adr_o_p,
    output logic [31:0]                   wbs_dat_o_p,
    input  logic                          wbs_ack_i_p,
    input  logic [31:0]                   wbs_dat_i_p,
    output logic [NUM_MANAGERS-1:0]       arb_grant_o,
    output logic                          arb_timeout_o
);

    localparam int IDX_W = $clog2(NUM_MANAGERS);
    localparam logic [IDX_W-1:0] LAST_AT_RESET = IDX_W'(NUM_MANAGERS - 1);
    localparam logic [NUM_MANAGERS-1:0] GRANT_LSB = NUM_MANAGERS'(1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Parameter sanity: elaboration fails on nonsensical configurations.
    if (NUM_MANAGERS < 2) begin : g_bad_num_managers
        $error("wishbone_arbiter: NUM_MANAGERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("wishbone_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1
    } state_t;
`endif

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]        last_reg, last_next;
    logic [NUM_MANAGERS-1:0] grant_reg, grant_next;

    // Round-robin search results
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    int                      cand_int;
    logic [IDX_W-1:0]        cand_idx;

    // Granted manager's inputs
    logic                    sel_cyc;
    logic                    sel_stb;
    logic                    sel_we;
    logic [3:0]              sel_sel;
    logic [31:0]             sel_adr;
    logic [31:0]             sel_dat;

    // Return path towards the granted lane
    logic                    route_en;
    logic                    ack_src;
    logic [31:0]             dat_src;

    // Stall counter; only meaningful with the timeout feature
    logic                    timeout_hit;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]              cnt_reg, cnt_next;
`endif

    assign sel_cyc = wbm_cyc_i[grant_idx_reg];
    assign sel_stb = wbm_stb_i[grant_idx_reg];
    assign sel_we  = wbm_we_i[grant_idx_reg];
    assign sel_sel = wbm_sel_i[grant_idx_reg];
    assign sel_adr = wbm_adr_i[grant_idx_reg];
    assign sel_dat = wbm_dat_i[grant_idx_reg];

    // Find the first requester after last_reg, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_int   = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_MANAGERS; k++) begin
            cand_int = int'(last_reg) + k;
            if (cand_int >= NUM_MANAGERS) begin
                cand_int = cand_int - NUM_MANAGERS;
            end
            cand_idx = IDX_W'(cand_int);
            if (!pick_found && wbm_cyc_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    // Stall counter: counts unacked strobe cycles of the current grant.
    always_comb begin
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        if (state_reg == ST_BUSY) begin
            if (!sel_cyc || wbs_ack_i_p) begin
                cnt_next = '0;
            end else if (sel_stb) begin
                cnt_next = 8'(cnt_reg + 8'd1);
                // A real ack in the same cycle takes the branch above instead.
                timeout_hit = (cnt_next == TIMEOUT_LIMIT);
            end
        end else begin
            cnt_next = '0;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State, grant and round-robin pointer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            grant_idx_reg <= '0;
            last_reg      <= LAST_AT_RESET;
            grant_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
        end
    end

    // Next-state logic and shared-port outputs.
    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        last_next      = last_reg;
        grant_next     = grant_reg;
        wbs_cyc_o_p    = 1'b0;
        wbs_stb_o_p    = 1'b0;
        wbs_we_o_p     = 1'b0;
        wbs_sel_o_p    = '0;
        wbs_adr_o_p    = '0;
        wbs_dat_o_p    = '0;
        route_en       = 1'b0;
        ack_src        = 1'b0;
        dat_src        = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next     = ST_BUSY;
                    grant_idx_next = pick_idx;
                    last_next      = pick_idx;
                    grant_next     = GRANT_LSB << pick_idx;
                end
            end
            ST_BUSY: begin
                wbs_cyc_o_p = sel_cyc;
                wbs_stb_o_p = sel_stb;
                wbs_we_o_p  = sel_we;
                wbs_sel_o_p = sel_sel;
                wbs_adr_o_p = sel_adr;
                wbs_dat_o_p = sel_dat;
                route_en    = 1'b1;
                ack_src     = wbs_ack_i_p;
                dat_src     = wbs_dat_i_p;
                if (!sel_cyc) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_TIMEOUT: begin
                // Shared cyc/stb stay low; the stuck manager gets a fake ack.
                route_en   = 1'b1;
                ack_src    = 1'b1;
                dat_src    = TIMEOUT_DATA;
                state_next = ST_IDLE;
                grant_next = '0;
                last_next  = grant_idx_reg;
            end
`endif
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Per-manager return lanes: only the granted lane sees ack/data.
    for (genvar gi = 0; gi < NUM_MANAGERS; gi++) begin : g_lane
        assign wbm_ack_o[gi] = route_en && grant_reg[gi] && ack_src;
        assign wbm_dat_o[gi] = (route_en && grant_reg[gi]) ? dat_src : 32'h0;
    end

    assign arb_grant_o = grant_reg;

`ifdef WB_ARB_TIMEOUT_EN
    assign arb_timeout_o = (state_reg == ST_TIMEOUT);
`else
    assign arb_timeout_o = 1'b0;
`endif

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Round-robin arbiter that shares the single Wishbone manager port of the interconnect between `NUM_MANAGERS` requesters. It sits between the managers and `wishbone_decoder`: it selects one manager, forwards that manager's cycle signals to the decoder, and routes the decoder's registered ack/data back to the granted manager only. A grant is held for the whole Wishbone cycle (`cyc` high), so the decoder sees a single uninterrupted transaction stream.

## Interface
- `NUM_MANAGERS`, 3: number of requesting managers, ≥2.
- `TIMEOUT_CYCLES`, 255: cycles without ack before forced termination. Used only with `WB_ARB_TIMEOUT_EN`; 8-bit counter, range 1..255.
- `CLK` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `wbm_cyc_i` in [NUM_MANAGERS-1:0]: per-manager cycle request.
- `wbm_stb_i` in [NUM_MANAGERS-1:0]: per-manager strobe.
- `wbm_we_i` in [NUM_MANAGERS-1:0]: per-manager write enable.
- `wbm_sel_i` in [NUM_MANAGERS-1:0][3:0]: per-manager byte select.
- `wbm_adr_i` in [NUM_MANAGERS-1:0][31:0]: per-manager address.
- `wbm_dat_i` in [NUM_MANAGERS-1:0][31:0]: per-manager write data.
- `wbm_ack_o` out [NUM_MANAGERS-1:0]: ack to each manager; only the granted bit can be high.
- `wbm_dat_o` out [NUM_MANAGERS-1:0][31:0]: read data; granted manager gets shared data, others 0.
- `wbs_cyc_o_p`, `wbs_stb_o_p`, `wbs_we_o_p` out 1: shared cycle, strobe, write enable to decoder.
- `wbs_sel_o_p` out 4, `wbs_adr_o_p` out 32, `wbs_dat_o_p` out 32: shared select, address, write data to decoder.
- `wbs_ack_i_p` in 1, `wbs_dat_i_p` in 32: ack and read data from decoder.
- `arb_grant_o` out [NUM_MANAGERS-1:0]: one-hot current grant, 0 when idle.
- `arb_timeout_o` out 1: one-cycle pulse on forced termination.

## Operation
- States: IDLE, BUSY, TIMEOUT (TIMEOUT exists only with `WB_ARB_TIMEOUT_EN`).
- IDLE: all shared outputs 0, all `wbm_ack_o`/`wbm_dat_o` 0. If any `wbm_cyc_i` bit is high, pick the first requester searching from `last+1` upward, wrapping modulo `NUM_MANAGERS`. Register grant index and `last`; go to BUSY.
- BUSY: shared outputs driven combinationally from the granted manager's inputs. `wbs_ack_i_p`/`wbs_dat_i_p` are routed to the granted manager's bit/lane. Requests from other managers are ignored.
- BUSY → IDLE when the granted manager's `wbm_cyc_i` is low. The shared `cyc` drops in that same cycle because it is combinational from the manager.
- A manager holding `cyc` high keeps the grant indefinitely, which covers block and RMW cycles.
- Simultaneous requests: the winner is the nearest index after `last` in round-robin order. A manager that has just released cannot win again while another manager requests.
- Requests that arrive during BUSY wait. There is no preemption.
- Reset, including mid-transaction: state IDLE, grant 0, `last` = `NUM_MANAGERS-1` so manager 0 wins first, timeout counter 0, all outputs 0.

## Timing
- Arbitration latency: grant is visible 1 cycle after `cyc` is first seen in IDLE. Shared `cyc` is high from that cycle onward.
- There is at least one IDLE cycle between consecutive grants.
- Ack and read data pass through with zero added latency. The decoder's own registered ack latency still applies.
- `arb_grant_o` is registered and matches the state: one-hot in BUSY/TIMEOUT, 0 in IDLE.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - In BUSY, an 8-bit counter increments each cycle with shared `stb` high and `wbs_ack_i_p` low, and clears on ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter enters TIMEOUT for one cycle. In that cycle it forces shared `cyc`/`stb` to 0, drives the granted manager's `wbm_ack_o` = 1 and `wbm_dat_o` = 32'hDEAD_BEEF, and pulses `arb_timeout_o`.
  - After TIMEOUT the arbiter returns to IDLE and updates `last`.
  - A real ack arriving in the same cycle the limit is reached wins, and no timeout occurs.
- Not defined: no counter and no TIMEOUT state; `arb_timeout_o` tied 0. A slave that never acks hangs the bus.

## Test plan
- Single request: reset, then manager 1 raises cyc/stb, adr 32'h3200_0004. Required: grant 3'b010 next cycle, `wbs_adr_o_p` = 32'h3200_0004; ack with data 32'h1234_5678 reaches `wbm_ack_o[1]` and `wbm_dat_o[1]` only.
- Simultaneous requests: all three managers raise cyc right after reset. Required grant order 0, 1, 2, each manager holding for one transaction, with one IDLE cycle between grants.
- Fairness: manager 0 re-requests immediately after each release while manager 2 is also requesting. Required order 0, 2, 0, 2.
- Held cycle: manager 2 performs 4 back-to-back acked transfers with cyc held high while manager 0 requests. Required: manager 0 is granted only after manager 2 drops cyc.
- Reset mid-transaction: assert `RST` in BUSY. Required next cycle: all outputs 0 and grant 0; after release, manager 0 wins a simultaneous 0/1 request.
- Timeout (macro on, `TIMEOUT_CYCLES` = 8): the slave never acks. Required: after 8 stalled cycles, `wbm_ack_o` pulses for one cycle with 32'hDEAD_BEEF, `arb_timeout_o` = 1, and the arbiter is in IDLE the next cycle.
